// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared funct encodings for the pipelined multiplier
package mul_pkg;

  typedef logic [1:0] funct_t;

  localparam funct_t FN_MUL    = 2'b00;
  localparam funct_t FN_MULH   = 2'b01;
  localparam funct_t FN_MULHSU = 2'b10;
  localparam funct_t FN_MULHU  = 2'b11;

endpackage

// File: rtl/pipe_mul_slot.sv
// rtl/pipe_mul_slot.sv - single valid/ready register slot with flush
module pipe_mul_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // The slot can take new data when empty or when its content leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  // Valid bit follows the upstream handshake; payload only loads on a real transfer
  // so a stalled result stays bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (in_ready && in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_mul.sv
// rtl/pipe_mul.sv - parametrised valid/ready pipelined RV32M-style multiplier
module pipe_mul
  import mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [1:0]       funct,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = XLEN + TAG_W;

  // Stage-1 operand register: operands already extended by one bit so a
  // single signed multiply covers all four modes.
  logic             s1_valid;
  logic [XLEN:0]    s1_a;
  logic [XLEN:0]    s1_b;
  funct_t           s1_funct;
  logic [TAG_W-1:0] s1_tag;

  // Per-stage handshake chain; index 0 is stage 1, STAGES-1 drives the outputs.
  logic [STAGES-1:0]         v;
  logic [STAGES-1:0]         rdy;
  logic [STAGES-1:0][PW-1:0] d;

  logic accept;
  logic sign_a;
  logic sign_b;

  assign sign_a = (funct == FN_MULH) || (funct == FN_MULHSU);
  assign sign_b = (funct == FN_MULH);

  assign in_ready = !s1_valid || rdy[0];
  assign accept   = in_valid && in_ready && !flush;

  // Stage 1 captures the extended operands, mode and tag on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_funct <= FN_MUL;
      s1_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_a     <= {sign_a & op_a[XLEN-1], op_a};
        s1_b     <= {sign_b & op_b[XLEN-1], op_b};
        s1_funct <= funct;
        s1_tag   <= in_tag;
      end
    end
  end

  // Sign-extending both operands to 2*XLEN makes a plain modulo-2^(2*XLEN)
  // multiply equal to the true signed product in the kept bits.
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sel;

  assign ext_a = {{(XLEN-1){s1_a[XLEN]}}, s1_a};
  assign ext_b = {{(XLEN-1){s1_b[XLEN]}}, s1_b};
  assign prod  = ext_a * ext_b;
  assign sel   = (s1_funct == FN_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign v[0]          = s1_valid;
  assign d[0]          = {sel, s1_tag};
  assign rdy[STAGES-1] = out_ready;

  // Result/tag slots for stages 2..STAGES; none exist when STAGES is 1.
  for (genvar k = 1; k < STAGES; k++) begin : g_slot
    pipe_mul_slot #(
      .W(PW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (v[k-1]),
      .in_ready  (rdy[k-1]),
      .in_data   (d[k-1]),
      .out_valid (v[k]),
      .out_ready (rdy[k]),
      .out_data  (d[k])
    );
  end

  assign out_valid             = v[STAGES-1];
  assign {out_result, out_tag} = d[STAGES-1];
  assign busy                  = |v;

endmodule
